// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point radix-2 DIF FFT sequencer.
package fft16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned N              = 16;
    localparam int unsigned NSTAGE         = 4;
    localparam int unsigned BF_PER_STAGE   = 8;
    localparam int unsigned BF_LAT_DEFAULT = 2;

endpackage

// File: rtl/fft16_addr_gen.sv
// Combinational butterfly address and twiddle generator for one (stage, butterfly) pair.
// half = 8 >> stage, j = bf mod half, g = bf / half
// addrA = 2*g*half + j, addrB = addrA + half, twAddr = j << stage.
module fft16_addr_gen
    import fft16_pkg::*;
#(
    parameter int unsigned WN = 3,
    parameter int unsigned AW = 4
) (
    input  logic [1:0]    stage,
    input  logic [2:0]    bf,
    output logic [AW-1:0] addrA,
    output logic [AW-1:0] addrB,
    output logic [WN-1:0] twAddr
);

    localparam int unsigned HALF0 = N / 2;

    logic [3:0] half;
    logic [3:0] j;
    logic [3:0] g;
    logic [3:0] baseA;
    logic [3:0] twFull;

    // Decompose the butterfly index into group and offset, then form addresses.
    // The group base and offset occupy disjoint bits, so OR replaces the add.
    always_comb begin
        half   = 4'(HALF0 >> stage);
        j      = {1'b0, bf} & (half - 4'd1);
        g      = {1'b0, bf} >> (2'd3 - stage);
        baseA  = (g << (3'd4 - {1'b0, stage})) | j;
        twFull = j << stage;
        addrA  = AW'(baseA);
        addrB  = AW'(baseA + half);
        twAddr = WN'(twFull);
    end

endmodule

// File: rtl/fft16_tw_sched.sv
// Stage/butterfly sequencer for the 16-point DIF FFT: issues one butterfly per
// cycle, inserts BF_LAT drain cycles after each stage, pulses oDONE at the end.
// Every output is a register, so outputs reflect the state of the previous cycle.
module fft16_tw_sched
    import fft16_pkg::*;
#(
    parameter int unsigned WN     = 3,
    parameter int unsigned AW     = 4,
    parameter int unsigned BF_LAT = BF_LAT_DEFAULT
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iSTART,
    input  logic          iSTALL,
    output logic          oBUSY,
    output logic          oBF_VALID,
    output logic [AW-1:0] oADDR_A,
    output logic [AW-1:0] oADDR_B,
    output logic [WN-1:0] oTW_ADDR,
    output logic [1:0]    oSTAGE,
    output logic          oBANK,
    output logic          oLAST_BF,
    output logic          oDONE
);

    localparam logic [1:0] LAST_STAGE = 2'(NSTAGE - 1);
    localparam logic [2:0] LAST_BF    = 3'(BF_PER_STAGE - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(BF_LAT - 1);

    state_t        state;
    logic [1:0]    stageCnt;
    logic [2:0]    bfCnt;
    logic [2:0]    flushCnt;
    logic [AW-1:0] genA;
    logic [AW-1:0] genB;
    logic [WN-1:0] genTw;

    fft16_addr_gen #(
        .WN (WN),
        .AW (AW)
    ) uAddrGen (
        .stage  (stageCnt),
        .bf     (bfCnt),
        .addrA  (genA),
        .addrB  (genB),
        .twAddr (genTw)
    );

    // Sequencer FSM with registered issue outputs; address, twiddle, stage and
    // bank only update on an actual issue, so they hold through stalls and gaps.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            stageCnt  <= '0;
            bfCnt     <= '0;
            flushCnt  <= '0;
            oBUSY     <= 1'b0;
            oBF_VALID <= 1'b0;
            oADDR_A   <= '0;
            oADDR_B   <= '0;
            oTW_ADDR  <= '0;
            oSTAGE    <= '0;
            oBANK     <= 1'b0;
            oLAST_BF  <= 1'b0;
            oDONE     <= 1'b0;
        end else begin
            oBF_VALID <= 1'b0;
            oLAST_BF  <= 1'b0;
            oDONE     <= 1'b0;
            oBUSY     <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state    <= RUN;
                        stageCnt <= '0;
                        bfCnt    <= '0;
                        flushCnt <= '0;
                    end
                end
                RUN: begin
                    if (!iSTALL) begin
                        oBF_VALID <= 1'b1;
                        oADDR_A   <= genA;
                        oADDR_B   <= genB;
                        oTW_ADDR  <= genTw;
                        oSTAGE    <= stageCnt;
                        oBANK     <= stageCnt[0];
                        oLAST_BF  <= (bfCnt == LAST_BF);
                        if (bfCnt == LAST_BF) begin
                            state    <= FLUSH;
                            flushCnt <= '0;
                        end else begin
                            bfCnt <= bfCnt + 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (flushCnt == FLUSH_LAST) begin
                        bfCnt <= '0;
                        if (stageCnt == LAST_STAGE) begin
                            state <= DONE;
                        end else begin
                            stageCnt <= stageCnt + 2'd1;
                            state    <= RUN;
                        end
                    end else begin
                        flushCnt <= flushCnt + 3'd1;
                    end
                end
                DONE: begin
                    oDONE <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fft16_tw_sched.md
# fft16_tw_sched

Sequencer for the 16-point radix-2 DIF FFT datapath. On a start pulse it walks 4 stages × 8 butterflies and issues, every cycle, one butterfly's operand addresses and the 3-bit twiddle address for the twiddle ROM (TW_ROM, W16^k, k = 0..7). It inserts drain gaps between stages so the butterfly pipeline's writes land before the next stage reads them. It sits between the top-level control and the butterfly / sample-RAM / twiddle-ROM datapath.

## Interface
- WN, 3, twiddle address width (matches the twiddle ROM)
- AW, 4, sample address width (16 points)
- BF_LAT, 2, butterfly read-to-write latency in cycles; also the drain gap length, legal range 1..7
- CLK  in  1  clock, rising edge
- nRST  in  1  reset; one clock, asynchronous, active-low
- iSTART  in  1  start request, sampled in IDLE only
- iSTALL  in  1  downstream hold; freezes issue while in RUN
- oBUSY  out  1  high in RUN, FLUSH and DONE
- oBF_VALID  out  1  addresses and twiddle on this cycle are a valid butterfly issue
- oADDR_A  out  AW  upper-leg sample address
- oADDR_B  out  AW  lower-leg sample address
- oTW_ADDR  out  WN  twiddle ROM address k (W16^k)
- oSTAGE  out  2  current stage 0..3
- oBANK  out  1  read bank for the current stage; writes go to ~oBANK
- oLAST_BF  out  1  qualifies the last butterfly of the current stage (with oBF_VALID)
- oDONE  out  1  one-cycle completion pulse

## Operation
- **State machine:** IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN when iSTART=1. Stage and butterfly counters clear to 0.
  - RUN: issue butterfly b of stage s. b increments when iSTALL=0.
  - RUN → FLUSH after b=7 is issued with iSTALL=0.
  - FLUSH lasts exactly BF_LAT cycles. It ignores iSTALL.
  - FLUSH → RUN with s+1 and b=0, or FLUSH → DONE if s=3.
  - DONE lasts 1 cycle, then → IDLE.
- **Address rule** (half = 8 >> s, j = b mod half, g = b / half):
  - ADDR_A = 2·g·half + j
  - ADDR_B = ADDR_A + half
  - TW_ADDR = (j << s), truncated to WN bits; always 0..7.
- **Bank:** oBANK = s[0], i.e. it toggles each stage and is 0 in stage 0.
- **Ignored inputs:**
  - iSTART outside IDLE has no effect and is not queued.
  - iSTALL outside RUN has no effect.
- **Stall:** while in RUN with iSTALL=1, oBF_VALID=0 and the address, twiddle, stage and bank outputs hold their last values. A stall on b=7 delays the FLUSH entry.
- **Reset:**
  - nRST low at any time, including mid-FFT, returns to IDLE immediately.
  - Reset values: all outputs 0, state IDLE, counters 0.
  - No partial-transform recovery; the host restarts.

## Timing
- All outputs are registered.
- Start sampled at edge E0 → first issue (s=0, b=0, oBF_VALID=1) is valid after E1.
- No-stall schedule per stage: 8 issue cycles, then BF_LAT flush cycles.
- oDONE is high in the cycle after edge E(4·(8+BF_LAT)) + 1. With BF_LAT=2 that is E41.
- oBUSY rises after E1 and falls after the DONE cycle.
- A new iSTART may be sampled in the first IDLE cycle after DONE. No back-to-back overlap.
- oLAST_BF is high only in the cycle oBF_VALID=1 with b=7.
- Each stall cycle extends total latency by exactly 1 cycle.
- Twiddle ROM output is combinational, so the datapath sees twiddle data in the same cycle as oTW_ADDR.

## Structure
- **Package fft16_pkg:**
  - state enum (IDLE/RUN/FLUSH/DONE)
  - constants N=16, NSTAGE=4, BF_PER_STAGE=8, default BF_LAT
- **Sub-module fft16_addr_gen:** purely combinational (s, b) → (ADDR_A, ADDR_B, TW_ADDR). The scheduler registers its outputs. It is reused by the verification model.
- **Top:** FSM, 2-bit stage counter, 3-bit butterfly counter, 3-bit flush counter.

## Test plan
- **Reset then start, BF_LAT=2:** one-cycle iSTART → exactly 32 oBF_VALID cycles; oDONE high at E41; oBUSY low afterwards.
- **Address/twiddle check** (expected A/B/k):
  - s0 b3 → 3/11/3
  - s1 b5 → 9/13/2
  - s2 b6 → 12/14/0
  - s2 b7 → 13/15/4
  - s3 b4 → 8/9/0
  - oBANK: 0, 1, 0, 1 across stages.
- **Stall:** iSTALL high for 3 cycles at s1 b7 → oBF_VALID=0 and outputs held; b7 issued once; FLUSH entered one cycle after the release; oDONE delayed by exactly 3 cycles.
- **Ignored inputs:**
  - iSTART pulses during RUN and FLUSH → no effect; exactly one oDONE.
  - iSTALL during FLUSH → gap length unchanged.
- **Async reset mid-run:** nRST low at s2 b4 → all outputs 0 without waiting for a clock edge; a subsequent iSTART runs a full clean 40+1-cycle sequence.
- **Back-to-back:** iSTART asserted in the first IDLE cycle after oDONE → second transform identical to the first, shifted in time.
